// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit bus processor: opcodes, control-unit
// timesteps and ALU function codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    MV  = 3'b000,
    MVI = 3'b001,
    ADD = 3'b010,
    SUB = 3'b011,
    AND = 3'b100,
    SLT = 3'b101,
    LD  = 3'b110,
    ST  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  // ALU opcodes 010..101 map onto 00..11 by flipping bit 1.
  function automatic logic [1:0] alu_sel(input logic [2:0] opc);
    return opc[1:0] ^ 2'b10;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit binary to 8-bit one-hot register selector.
module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  assign onehot = 8'b1 << sel;

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetches an instruction into IR in T0 and
// drives the bus selects and load enables through T1..T3.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] din,
  output logic        dinout,
  output logic [7:0]  r_out,
  output logic        g_out,
  output logic        dout_out,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic        addr_in,
  output logic        wrdata_in,
  output logic        w_en,
  output logic [1:0]  alu_op,
  output logic        done,
  output state_t      state
);

  state_t     next_state;
  logic [8:0] ir;
  logic       ir_load;
  opcode_t    opcode;
  logic [7:0] rx_oh;
  logic [7:0] ry_oh;
  logic       unused_bits;

  // Only opcode/rx/ry are kept; IR[6:0] carries no control information.
  assign unused_bits = ^din[6:0];
  assign opcode      = opcode_t'(ir[8:6]);

  dec3to8 u_dec_rx (.sel(ir[5:3]), .onehot(rx_oh));
  dec3to8 u_dec_ry (.sel(ir[2:0]), .onehot(ry_oh));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (ir_load) ir <= din[15:7];
    end
  end

  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    r_out      = '0;
    g_out      = 1'b0;
    dout_out   = 1'b0;
    r_in       = '0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    addr_in    = 1'b0;
    wrdata_in  = 1'b0;
    w_en       = 1'b0;
    alu_op     = ALU_ADD;
    done       = 1'b0;

    unique case (state)
      T0: begin
        ir_load = run;
        if (run) next_state = T1;
      end
      T1: begin
        unique case (opcode)
          MV:  begin r_out = ry_oh; r_in = rx_oh; done = 1'b1; end
          MVI: begin r_in = rx_oh; done = 1'b1; end
          ADD, SUB, AND, SLT: begin r_out = rx_oh; a_in = 1'b1; end
          LD, ST: begin r_out = ry_oh; addr_in = 1'b1; end
          default: ;
        endcase
        if (!done) next_state = T2;
      end
      T2: begin
        unique case (opcode)
          ADD, SUB, AND, SLT: begin
            r_out  = ry_oh;
            g_in   = 1'b1;
            alu_op = alu_sel(opcode);
          end
          ST: begin
            r_out     = rx_oh;
            wrdata_in = 1'b1;
            w_en      = 1'b1;
            done      = 1'b1;
          end
          default: ;
        endcase
        next_state = (opcode inside {ADD, SUB, AND, SLT, LD}) ? T3 : T0;
      end
      T3: begin
        unique case (opcode)
          ADD, SUB, AND, SLT: begin g_out = 1'b1; r_in = rx_oh; done = 1'b1; end
          LD: begin dout_out = 1'b1; r_in = rx_oh; done = 1'b1; end
          default: ;
        endcase
        next_state = T0;
      end
      default: next_state = T0;
    endcase

    if (done) next_state = T0;

    // Reset silences every enable combinationally so nothing can pulse
    // between resetn falling and the state register clearing.
    if (!resetn) begin
      ir_load   = 1'b0;
      r_out     = '0;
      g_out     = 1'b0;
      dout_out  = 1'b0;
      r_in      = '0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      addr_in   = 1'b0;
      wrdata_in = 1'b0;
      w_en      = 1'b0;
      alu_op    = ALU_ADD;
      done      = 1'b0;
    end

    // din drives the bus whenever no other source is selected.
    dinout = ~(|r_out | g_out | dout_out);
  end

endmodule
